// File: rtl/cdb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : cdb_arbiter
// Purpose  : Round-robin grant of the common data bus to one output buffer.
// Revision : 1.0  initial release
// ============================================================================
module cdb_arbiter #(
  parameter int NUM_REQUESTERS = 4,
  parameter int INDEX_WIDTH    = (NUM_REQUESTERS > 1) ? $clog2(NUM_REQUESTERS) : 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQUESTERS-1:0] request,
  input  logic                      hold,
  output logic [NUM_REQUESTERS-1:0] permit,
  output logic                      cdb_valid,
  output logic [INDEX_WIDTH-1:0]    grant_index,
  output logic [INDEX_WIDTH-1:0]    priority_ptr
);

  localparam int                     c_sum_w = INDEX_WIDTH + 1;
  localparam logic [INDEX_WIDTH:0]   c_num   = c_sum_w'(NUM_REQUESTERS);
  localparam logic [INDEX_WIDTH-1:0] c_last  = INDEX_WIDTH'(NUM_REQUESTERS - 1);

  logic [INDEX_WIDTH-1:0]    r_ptr;
  logic [INDEX_WIDTH:0]      w_sum;
  logic [INDEX_WIDTH-1:0]    w_idx;
  logic [NUM_REQUESTERS-1:0] w_permit;
  logic [INDEX_WIDTH-1:0]    w_grant_index;
  logic                      w_found;
  logic [INDEX_WIDTH-1:0]    w_ptr_next;

  // Walk the ring starting at r_ptr; the first requester seen wins. The extra
  // sum bit lets the wrap work for non-power-of-two requester counts.
  always_comb begin
    w_sum         = '0;
    w_idx         = '0;
    w_permit      = '0;
    w_grant_index = '0;
    w_found       = 1'b0;
    if (reset && !hold) begin
      for (int k = 0; k < NUM_REQUESTERS; k++) begin
        w_sum = {1'b0, r_ptr} + c_sum_w'(k);
        if (w_sum >= c_num) begin
          w_sum = w_sum - c_num;
        end
        w_idx = w_sum[INDEX_WIDTH-1:0];
        if (!w_found && request[w_idx]) begin
          w_found         = 1'b1;
          w_permit[w_idx] = 1'b1;
          w_grant_index   = w_idx;
        end
      end
    end
  end

  always_comb begin
    w_ptr_next = r_ptr;
    if (w_found) begin
      w_ptr_next = (w_grant_index == c_last) ? '0 : w_grant_index + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_ptr <= '0;
    end else begin
      r_ptr <= w_ptr_next;
    end
  end

  assign permit       = w_permit;
  assign cdb_valid    = w_found;
  assign grant_index  = w_grant_index;
  assign priority_ptr = r_ptr;

endmodule
`default_nettype wire

// File: doc/cdb_arbiter.md
# cdb_arbiter

Round-robin arbiter for the common data bus (CDB). It takes the `not_empty` flags of every `functional_unit_output_buffer` and grants at most one of them the bus per cycle. For the winner it drives that buffer's `data_bus_permit` and asserts `cdb_valid`, so that reservation stations, `reservation_station_reset` and the reorder buffer capture the broadcast at the next rising edge. A registered rotating-priority pointer guarantees that every persistently requesting buffer is served within NUM_REQUESTERS grant cycles.

## Interface
Parameters:
- NUM_REQUESTERS, default 4: number of output buffers sharing the CDB; must be at least 1.
- INDEX_WIDTH, default $clog2(NUM_REQUESTERS) (minimum 1): width of the grant index and of the priority pointer.

Ports:
- clk  input  1  the single clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-low reset.
- request  input  NUM_REQUESTERS  bit i is `not_empty` of output buffer i.
- hold  input  1  when 1, no grant is issued this cycle (ROB back-pressure or flush).
- permit  output  NUM_REQUESTERS  one-hot or zero; bit i drives `data_bus_permit` of buffer i.
- cdb_valid  output  1  1 exactly when any permit bit is 1.
- grant_index  output  INDEX_WIDTH  binary index of the granted requester; 0 when cdb_valid is 0.
- priority_ptr  output  INDEX_WIDTH  current highest-priority index, exported for debug and verification.

## Operation
- **State:** a single register `ptr`, the index with highest priority this cycle.
- **Grant (combinational):**
  - Scan indices ptr, ptr+1, …, NUM_REQUESTERS-1, 0, …, ptr-1, in that order.
  - The first i with request[i]=1 wins: permit = 1<<i, grant_index = i, cdb_valid = 1.
- **No grant:** if request is all zeros, or hold=1, or reset=0, then permit=0, cdb_valid=0 and grant_index=0.
- **Pointer update (rising edge):**
  - reset=0: ptr ← 0.
  - A grant to i occurred: ptr ← (i+1) mod NUM_REQUESTERS. The wrap from NUM_REQUESTERS-1 goes to 0, including when NUM_REQUESTERS is not a power of two.
  - Otherwise: ptr is unchanged.
- **Request sampling:** request bits are used as presented in the current cycle. No request is latched; a request dropped before the edge is simply not served.
- **Bus safety:** at most one permit bit is ever 1. This is required so that the tri-stated `cdb_data`/`cdb_rob_tag` never have two drivers.
- **hold:** takes effect combinationally in the same cycle and freezes ptr.
- **Reset mid-operation:** a grant in progress is cancelled in the same cycle (outputs gated low). ptr is 0 after the edge. Pending buffer contents are unaffected; buffers have their own reset.
- **NUM_REQUESTERS=1:** permit[0] = request[0] & ~hold & reset; ptr stays 0.

## Timing
- **Grant latency:** zero cycles. A request asserted in cycle t, if it wins, produces permit/cdb_valid in cycle t. The buffer's data and tag appear on the CDB in cycle t, and consumers capture them at the end of cycle t.
- **Handshake:**
  - The buffer treats permit=1 at the rising edge as "dequeued".
  - If the buffer's not_empty remains 1 afterwards, it re-enters arbitration the next cycle at the lowest priority relative to the others.
- **Throughput:** one broadcast per cycle while any request is present and hold=0.
- **Fairness bound:** a requester held high with hold=0 is granted within NUM_REQUESTERS consecutive cycles.
- **Reset values:**
  - ptr = 0 and priority_ptr = 0.
  - permit = 0, cdb_valid = 0 and grant_index = 0 during and immediately after reset, until a request is present.
- **Outputs:** permit, cdb_valid and grant_index are purely combinational from request, hold, reset and ptr. priority_ptr is registered.

## Test plan
- **Reset:** hold reset=0 for 1 cycle with request=4'b1111 → permit=0, cdb_valid=0, priority_ptr=0. After release with request=4'b1111: permit=4'b0001 and grant_index=0 in the first cycle.
- **Rotation:** request=4'b1111 held for 5 cycles → permit sequence 0001, 0010, 0100, 1000, 0001; priority_ptr sequence 0, 1, 2, 3, 0; cdb_valid=1 every cycle.
- **Skip and wrap:** with ptr=3, request=4'b0101 → permit=0001 (index 0, wrapped); next cycle ptr=1 and request=0101 → permit=0100, ptr becomes 3.
- **Hold and idle:** with ptr=2 and request=4'b0100, hold=1 for 2 cycles → permit=0, cdb_valid=0, ptr stays 2. Then hold=0 → permit=0100 and ptr=3. Then request=0 → cdb_valid=0 and ptr stays 3.
- **End-to-end:** one ALU functional unit whose output buffer holds value 41 with tag 19, connected at index 1 with request=4'b0010 → cdb_data=41, cdb_rob_tag=19 and cdb_valid=1 in the same cycle. Next cycle: the reservation station holding tag 19 has reset (busy=0), request[1]=0, priority_ptr=2.
- **Mutual exclusion:** random request/hold/reset for 10k cycles → permit is never more than one-hot; cdb_valid == |permit; each continuously requesting index is granted within 4 grant-eligible cycles.
